// File: rtl/csr_trap_file_pkg.sv
// csr_trap_file_pkg: shared definitions for the machine-mode CSR/trap block.
// Holds CSR addresses, mcause codes, mstatus/mie bit positions, the trap FSM
// state type and the default misa encoding helper.
package csr_trap_file_pkg;

  localparam logic [11:0] CSR_SSTATUS  = 12'h100;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  // mcause exception/interrupt codes (interrupt flag is the MSB)
  localparam int unsigned CAUSE_M_ECALL = 11;
  localparam int unsigned CAUSE_M_TIMER = 7;
  localparam int unsigned CAUSE_M_EXT   = 11;

  // mstatus / sstatus bit positions
  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;
  localparam int unsigned SSTATUS_XS_LO  = 13;
  localparam int unsigned SSTATUS_XS_HI  = 16;

  // mie / mip bit positions
  localparam int unsigned MIE_MTIE = 7;
  localparam int unsigned MIE_MEIE = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRAP = 2'd1,
    ST_RET  = 2'd2
  } trap_state_e;

  // misa with MXL matching the data width and only the I extension set
  function automatic logic [63:0] misa_default(input int unsigned xlen);
    return (xlen == 32) ? 64'h0000_0000_4000_0100 : 64'h8000_0000_0000_0100;
  endfunction

endpackage

// File: rtl/csr_trap_file_counters.sv
// csr_counters: mcycle / minstret counter pair.
//   cpu_clk_50M, cpu_rst_n : clock, async active-low reset
//   cycle_we, instret_we   : load the counter from wdata instead of counting
//   wdata                  : load value
//   inst_retire            : minstret increment request
//   mcycle, minstret       : counter values (wrap modulo 2^XLEN)
module csr_counters #(
  parameter int unsigned XLEN = 64
) (
  input  logic            cpu_clk_50M,
  input  logic            cpu_rst_n,
  input  logic            cycle_we,
  input  logic            instret_we,
  input  logic [XLEN-1:0] wdata,
  input  logic            inst_retire,
  output logic [XLEN-1:0] mcycle,
  output logic [XLEN-1:0] minstret
);

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle <= cycle_we ? wdata : mcycle + XLEN'(1);
      if (instret_we)
        minstret <= wdata;
      else if (inst_retire)
        minstret <= minstret + XLEN'(1);
    end
  end

endmodule

// File: rtl/csr_trap_file.sv
// csr_trap_file: machine-mode CSR file with trap entry / mret sequencing.
//   cpu_clk_50M, cpu_rst_n        : clock, async active-low reset
//   csr_raddr/csr_rdata           : combinational CSR read (same-cycle write bypass)
//   csr_waddr/csr_wdata/csr_we    : CSR write port
//   csr_illegal                   : unimplemented access or write to read-only CSR
//   inst_retire                   : minstret increment
//   ecall_req, mret_req, exc_pc   : writeback events and their PC
//   timer_irq, ext_irq            : level interrupt inputs
//   trap_taken/trap_target        : one-cycle redirect to mtvec (trap) or mepc (mret)
//   busy                          : FSM not idle
module csr_trap_file
  import csr_trap_file_pkg::*;
#(
  parameter int unsigned     XLEN      = 64,
  parameter logic [XLEN-1:0] HART_ID   = '0,
  parameter logic [XLEN-1:0] MTVEC_RST = '0,
  parameter logic [XLEN-1:0] MISA_VAL  = XLEN'(misa_default(XLEN))
) (
  input  logic            cpu_clk_50M,
  input  logic            cpu_rst_n,
  input  logic [11:0]     csr_raddr,
  output logic [XLEN-1:0] csr_rdata,
  input  logic [11:0]     csr_waddr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            csr_we,
  output logic            csr_illegal,
  input  logic            inst_retire,
  input  logic            ecall_req,
  input  logic            mret_req,
  input  logic [XLEN-1:0] exc_pc,
  input  logic            timer_irq,
  input  logic            ext_irq,
  output logic            trap_taken,
  output logic [XLEN-1:0] trap_target,
  output logic            busy
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  trap_state_e     state;
  logic            st_mie, st_mpie, st_sd;
  logic [1:0]      st_mpp;
  logic [3:0]      st_xs;
  logic            mie_mtie, mie_meie;
  logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [XLEN-1:0] mcycle, minstret;

  logic            wr_legal, rd_impl;
  logic [XLEN-1:0] wr_val, rd_val, trap_cause;
  logic            irq_e, irq_t, idle;
  logic            take_ext, take_tmr, take_ecall, take_trap, take_mret, wr_en;

  // Write-side decode: legality and the masked value that would be stored.
  always_comb begin
    wr_legal = 1'b1;
    wr_val   = csr_wdata;
    case (csr_waddr)
      CSR_MSTATUS: begin
        wr_val = '0;
        wr_val[MSTATUS_MIE]  = csr_wdata[MSTATUS_MIE];
        wr_val[MSTATUS_MPIE] = csr_wdata[MSTATUS_MPIE];
        wr_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = csr_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
      end
      CSR_MIE: begin
        wr_val = '0;
        wr_val[MIE_MTIE] = csr_wdata[MIE_MTIE];
        wr_val[MIE_MEIE] = csr_wdata[MIE_MEIE];
      end
      CSR_MTVEC, CSR_MEPC: wr_val = csr_wdata & ALIGN_MASK;
      CSR_MSCRATCH, CSR_MCAUSE, CSR_MCYCLE, CSR_MINSTRET: ;
      default: wr_legal = 1'b0;
    endcase
  end

  // Event arbitration, only while idle; exactly one winner per cycle.
  assign idle       = (state == ST_IDLE);
  assign irq_e      = ext_irq & mie_meie & st_mie;
  assign irq_t      = timer_irq & mie_mtie & st_mie;
  assign take_ext   = idle & irq_e;
  assign take_tmr   = idle & ~irq_e & irq_t;
  assign take_ecall = idle & ~irq_e & ~irq_t & ecall_req;
  assign take_trap  = take_ext | take_tmr | take_ecall;
  assign take_mret  = idle & ~take_trap & mret_req;
  assign wr_en      = idle & ~take_trap & ~take_mret & csr_we & wr_legal;

  always_comb begin
    trap_cause = XLEN'(CAUSE_M_ECALL);
    if (take_ext)
      trap_cause = {1'b1, (XLEN-1)'(CAUSE_M_EXT)};
    else if (take_tmr)
      trap_cause = {1'b1, (XLEN-1)'(CAUSE_M_TIMER)};
  end

  // Read-side decode.
  always_comb begin
    rd_impl = 1'b1;
    rd_val  = '0;
    case (csr_raddr)
      CSR_MSTATUS: begin
        rd_val[MSTATUS_MIE]  = st_mie;
        rd_val[MSTATUS_MPIE] = st_mpie;
        rd_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = st_mpp;
      end
      CSR_SSTATUS: begin
        rd_val[XLEN-1] = st_sd;
        rd_val[SSTATUS_XS_HI:SSTATUS_XS_LO] = st_xs;
      end
      CSR_MISA: rd_val = MISA_VAL;
      CSR_MIE: begin
        rd_val[MIE_MTIE] = mie_mtie;
        rd_val[MIE_MEIE] = mie_meie;
      end
      CSR_MTVEC:    rd_val = mtvec_q;
      CSR_MSCRATCH: rd_val = mscratch_q;
      CSR_MEPC:     rd_val = mepc_q;
      CSR_MCAUSE:   rd_val = mcause_q;
      CSR_MIP: begin
        rd_val[MIE_MTIE] = timer_irq;
        rd_val[MIE_MEIE] = ext_irq;
      end
      CSR_MCYCLE:   rd_val = mcycle;
      CSR_MINSTRET: rd_val = minstret;
      CSR_MHARTID:  rd_val = HART_ID;
      default:      rd_impl = 1'b0;
    endcase
  end

  // Bypass only writes that will actually land this cycle.
  assign csr_rdata   = (wr_en && (csr_waddr == csr_raddr)) ? wr_val : rd_val;
  assign csr_illegal = ~rd_impl | (csr_we & ~wr_legal);
  assign trap_target = (state == ST_TRAP) ? mtvec_q :
                       (state == ST_RET)  ? mepc_q  : '0;

  // Trap FSM with registered redirect/busy flags.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state      <= ST_IDLE;
      trap_taken <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= ST_IDLE;
      trap_taken <= 1'b0;
      busy       <= 1'b0;
      if (take_trap) begin
        state      <= ST_TRAP;
        trap_taken <= 1'b1;
        busy       <= 1'b1;
      end else if (take_mret) begin
        state      <= ST_RET;
        trap_taken <= 1'b1;
        busy       <= 1'b1;
      end
    end
  end

  // CSR state updates.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      st_mpp     <= 2'b00;
      st_sd      <= 1'b0;
      st_xs      <= '0;
      mie_mtie   <= 1'b0;
      mie_meie   <= 1'b0;
      mtvec_q    <= MTVEC_RST & ALIGN_MASK;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else if (take_trap) begin
      mepc_q   <= exc_pc & ALIGN_MASK;
      mcause_q <= trap_cause;
      st_mpie  <= st_mie;
      st_mie   <= 1'b0;
      st_mpp   <= 2'b11;
    end else if (take_mret) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
      st_mpp  <= 2'b00;
    end else if (wr_en) begin
      case (csr_waddr)
        CSR_MSTATUS: begin
          st_mie  <= wr_val[MSTATUS_MIE];
          st_mpie <= wr_val[MSTATUS_MPIE];
          st_mpp  <= wr_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
          // sstatus view bits are captured from the raw write data
          st_sd   <= csr_wdata[XLEN-1];
          st_xs   <= csr_wdata[SSTATUS_XS_HI:SSTATUS_XS_LO];
        end
        CSR_MIE: begin
          mie_mtie <= wr_val[MIE_MTIE];
          mie_meie <= wr_val[MIE_MEIE];
        end
        CSR_MTVEC:    mtvec_q    <= wr_val;
        CSR_MSCRATCH: mscratch_q <= wr_val;
        CSR_MEPC:     mepc_q     <= wr_val;
        CSR_MCAUSE:   mcause_q   <= wr_val;
        default: ;
      endcase
    end
  end

  csr_counters #(.XLEN(XLEN)) u_counters (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst_n   (cpu_rst_n),
    .cycle_we    (wr_en && (csr_waddr == CSR_MCYCLE)),
    .instret_we  (wr_en && (csr_waddr == CSR_MINSTRET)),
    .wdata       (csr_wdata),
    .inst_retire (inst_retire),
    .mcycle      (mcycle),
    .minstret    (minstret)
  );

endmodule

// File: tb/tb_csr_trap_file.sv
// tb_csr_trap_file: directed scenarios plus randomized traffic for csr_trap_file,
// checked against a behavioural CSR model; a second 32-bit instance covers the
// narrow configuration.
module tb_csr_trap_file;

  localparam logic [63:0] HART64  = 64'h5;
  localparam logic [63:0] MTVEC64 = 64'h1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] raddr, waddr;
  logic [63:0] wdata, exc_pc;
  logic        we, retire, ecall, mret, timer, ext;
  logic [63:0] rdata, ttgt;
  logic        illegal, tt, busy;

  logic [11:0] raddr32, waddr32;
  logic [31:0] wdata32, exc_pc32, rdata32, ttgt32;
  logic        we32, retire32, illegal32, tt32, busy32;

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  csr_trap_file #(.XLEN(64), .HART_ID(HART64), .MTVEC_RST(MTVEC64)) dut (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n),
    .csr_raddr(raddr), .csr_rdata(rdata), .csr_waddr(waddr), .csr_wdata(wdata),
    .csr_we(we), .csr_illegal(illegal), .inst_retire(retire),
    .ecall_req(ecall), .mret_req(mret), .exc_pc(exc_pc),
    .timer_irq(timer), .ext_irq(ext),
    .trap_taken(tt), .trap_target(ttgt), .busy(busy)
  );

  csr_trap_file #(.XLEN(32), .HART_ID(32'h7), .MTVEC_RST(32'h2000)) dut32 (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n),
    .csr_raddr(raddr32), .csr_rdata(rdata32), .csr_waddr(waddr32), .csr_wdata(wdata32),
    .csr_we(we32), .csr_illegal(illegal32), .inst_retire(retire32),
    .ecall_req(1'b0), .mret_req(1'b0), .exc_pc(exc_pc32),
    .timer_irq(1'b0), .ext_irq(1'b0),
    .trap_taken(tt32), .trap_target(ttgt32), .busy(busy32)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_st_mie, m_mpie, m_sd;
  logic [1:0]  m_mpp;
  logic [3:0]  m_xs;
  logic [63:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mcycle, m_minstret;
  int          m_mode;  // 0 idle, 1 redirect to mtvec, 2 redirect to mepc
  int          pending_w;

  task automatic model_reset();
    m_st_mie = 0; m_mpie = 0; m_sd = 0; m_mpp = 2'b00; m_xs = 4'h0;
    m_mie = 0; m_mtvec = MTVEC64 & ~64'h3; m_mscratch = 0; m_mepc = 0;
    m_mcause = 0; m_mcycle = 0; m_minstret = 0; m_mode = 0;
  endtask

  function automatic bit writable(input logic [11:0] a);
    return a == 12'h300 || a == 12'h304 || a == 12'h305 || a == 12'h340 ||
           a == 12'h341 || a == 12'h342 || a == 12'hB00 || a == 12'hB02;
  endfunction

  function automatic logic [63:0] wmask(input logic [11:0] a, input logic [63:0] d);
    case (a)
      12'h300: return d & 64'h1888;
      12'h304: return d & 64'h0880;
      12'h305, 12'h341: return d & ~64'h3;
      default: return d;
    endcase
  endfunction

  function automatic logic [63:0] m_read(input logic [11:0] a, output bit impl);
    logic [63:0] v;
    v = 0; impl = 1;
    case (a)
      12'h300: begin v[3] = m_st_mie; v[7] = m_mpie; v[12:11] = m_mpp; end
      12'h100: begin v[63] = m_sd; v[16:13] = m_xs; end
      12'h301: v = 64'h8000_0000_0000_0100;
      12'h304: v = m_mie;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h344: begin v[7] = timer; v[11] = ext; end
      12'hB00: v = m_mcycle;
      12'hB02: v = m_minstret;
      12'hF14: v = HART64;
      default: impl = 0;
    endcase
    return v;
  endfunction

  // 0 none, 1 ext irq, 2 timer irq, 3 ecall, 4 mret, 5 CSR write
  function automatic int winner();
    if (m_mode != 0) return 0;
    if (ext && m_mie[11] && m_st_mie) return 1;
    if (timer && m_mie[7] && m_st_mie) return 2;
    if (ecall) return 3;
    if (mret) return 4;
    if (we && writable(waddr)) return 5;
    return 0;
  endfunction

  task automatic model_apply(input int w);
    logic [63:0] nc, ni;
    nc = m_mcycle + 1;
    ni = m_minstret + (retire ? 64'd1 : 64'd0);
    m_mode = 0;
    case (w)
      1, 2, 3: begin
        m_mepc   = exc_pc & ~64'h3;
        m_mcause = (w == 1) ? 64'h8000_0000_0000_000B :
                   (w == 2) ? 64'h8000_0000_0000_0007 : 64'd11;
        m_mpie = m_st_mie; m_st_mie = 0; m_mpp = 2'b11; m_mode = 1;
      end
      4: begin m_st_mie = m_mpie; m_mpie = 1; m_mpp = 2'b00; m_mode = 2; end
      5: case (waddr)
        12'h300: begin
          m_st_mie = wdata[3]; m_mpie = wdata[7]; m_mpp = wdata[12:11];
          m_sd = wdata[63]; m_xs = wdata[16:13];
        end
        12'h304: m_mie = wdata & 64'h880;
        12'h305: m_mtvec = wdata & ~64'h3;
        12'h340: m_mscratch = wdata;
        12'h341: m_mepc = wdata & ~64'h3;
        12'h342: m_mcause = wdata;
        12'hB00: nc = wdata;
        12'hB02: ni = wdata;
        default: ;
      endcase
      default: ;
    endcase
    m_mcycle = nc;
    m_minstret = ni;
  endtask

  // Compare all outputs at the falling edge, using inputs driven after the rising edge.
  task automatic check_cycle();
    logic [63:0] exp_rd;
    bit impl;
    @(negedge clk);
    pending_w = winner();
    exp_rd = m_read(raddr, impl);
    if (pending_w == 5 && waddr == raddr) exp_rd = wmask(waddr, wdata);
    chk("rdata", rdata, exp_rd);
    chk("illegal", illegal, !impl || (we && !writable(waddr)));
    chk("trap_taken", tt, m_mode != 0);
    chk("busy", busy, m_mode != 0);
    if (m_mode != 0) chk("trap_target", ttgt, (m_mode == 1) ? m_mtvec : m_mepc);
  endtask

  task automatic tick();
    model_apply(pending_w);
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    we = 0; waddr = 12'h340; wdata = 0; raddr = 12'h300;
    retire = 0; ecall = 0; mret = 0; exc_pc = 0; timer = 0; ext = 0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    set_idle(); we = 1; waddr = a; wdata = d; raddr = a;
    check_cycle(); tick();
  endtask

  localparam logic [11:0] RADDRS [14] = '{12'h300, 12'h100, 12'h301, 12'h304, 12'h305,
    12'h340, 12'h341, 12'h342, 12'h344, 12'hB00, 12'hB02, 12'hF14, 12'h7C0, 12'h000};

  initial begin
    #10ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    set_idle();
    rst_n = 0;
    raddr32 = 12'h340; waddr32 = 12'h340; wdata32 = 0; exc_pc32 = 0; we32 = 0; retire32 = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // reset values and free-running mcycle
    for (int i = 0; i <= 10; i++) begin
      set_idle(); raddr = (i == 1) ? 12'h305 : 12'hB00;
      check_cycle();
      if (i == 0)  chk("rst_mcycle0", rdata, 64'd0);
      if (i == 1)  chk("rst_mtvec", rdata, MTVEC64);
      if (i == 10) chk("rst_mcycle10", rdata, 64'd10);
      tick();
    end

    // ecall
    wr(12'h300, 64'h8); wr(12'h340, 64'hAAAA); wr(12'h305, 64'h8000_0100);
    set_idle(); ecall = 1; exc_pc = 64'h8000_0040; raddr = 12'h342; check_cycle(); tick();
    set_idle(); raddr = 12'h341; check_cycle();
    chk("ecall_taken", tt, 1'b1);
    chk("ecall_target", ttgt, 64'h8000_0100);
    chk("ecall_mepc", rdata, 64'h8000_0040);
    tick();
    set_idle(); raddr = 12'h342; check_cycle();
    chk("ecall_mcause", rdata, 64'd11);
    chk("ecall_busy_clr", busy, 1'b0);
    tick();
    set_idle(); raddr = 12'h300; check_cycle(); chk("ecall_mstatus", rdata, 64'h1880); tick();

    // timer beats ecall, then mret with a write issued during RET
    wr(12'h300, 64'h8); wr(12'h304, 64'h80);
    set_idle(); timer = 1; ecall = 1; exc_pc = 64'h8000_0200; check_cycle(); tick();
    set_idle(); raddr = 12'h342; check_cycle();
    chk("tmr_taken", tt, 1'b1);
    chk("tmr_mcause", rdata, 64'h8000_0000_0000_0007);
    tick();
    set_idle(); mret = 1; check_cycle(); tick();
    set_idle(); we = 1; waddr = 12'h340; wdata = 64'h1234; raddr = 12'h340; check_cycle();
    chk("ret_taken", tt, 1'b1);
    chk("ret_target", ttgt, 64'h8000_0200);
    chk("ret_no_bypass", rdata, 64'hAAAA);
    tick();
    set_idle(); raddr = 12'h340; check_cycle(); chk("ret_mscratch", rdata, 64'hAAAA); tick();
    set_idle(); raddr = 12'h300; check_cycle(); chk("ret_mstatus", rdata, 64'h88); tick();

    // counter load and wrap
    set_idle(); we = 1; waddr = 12'hB02; wdata = '1; retire = 1; raddr = 12'hB02; check_cycle(); tick();
    set_idle(); retire = 1; raddr = 12'hB02; check_cycle(); chk("instret_ones", rdata, '1); tick();
    set_idle(); raddr = 12'hB02; check_cycle(); chk("instret_wrap", rdata, 64'd0); tick();
    wr(12'hB00, '1);
    set_idle(); raddr = 12'hB00; check_cycle(); chk("mcycle_ones", rdata, '1); tick();
    set_idle(); raddr = 12'hB00; check_cycle(); chk("mcycle_wrap", rdata, 64'd0); tick();

    // illegal accesses and the sstatus view
    set_idle(); we = 1; waddr = 12'hF14; wdata = '1; raddr = 12'hF14; check_cycle();
    chk("hartid_wr_illegal", illegal, 1'b1);
    chk("hartid_val", rdata, HART64);
    tick();
    set_idle(); raddr = 12'h7C0; check_cycle();
    chk("unimpl_illegal", illegal, 1'b1);
    chk("unimpl_rdata", rdata, 64'd0);
    tick();
    set_idle(); we = 1; waddr = 12'h100; wdata = '1; raddr = 12'h100; check_cycle();
    chk("sstatus_wr_illegal", illegal, 1'b1); tick();
    wr(12'h300, 64'h8000_0000_0001_E008);
    set_idle(); raddr = 12'h100; check_cycle(); chk("sstatus_view", rdata, 64'h8000_0000_0001_E000); tick();

    // reset during TRAP drops the redirect immediately
    set_idle(); ecall = 1; exc_pc = 64'h40; check_cycle(); tick();
    set_idle();
    #4 rst_n = 0;
    #1;
    chk("rst_abort_taken", tt, 1'b0);
    chk("rst_abort_busy", busy, 1'b0);
    model_reset();
    @(posedge clk); #1 rst_n = 1;

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      set_idle();
      raddr  = RADDRS[$urandom_range(13)];
      we     = ($urandom_range(9) < 3);
      waddr  = RADDRS[$urandom_range(13)];
      wdata  = {$urandom, $urandom};
      retire = $urandom_range(1);
      ecall  = ($urandom_range(19) == 0);
      mret   = ($urandom_range(19) == 0);
      exc_pc = {$urandom, $urandom};
      timer  = ($urandom_range(9) == 0);
      ext    = ($urandom_range(9) == 0);
      check_cycle(); tick();
    end
    set_idle();

    // 32-bit configuration
    we32 = 1; waddr32 = 12'hF14; wdata32 = '1; raddr32 = 12'hF14;
    @(negedge clk);
    chk("x32_hartid_wr_illegal", illegal32, 1'b1);
    chk("x32_hartid", rdata32, 64'h7);
    @(posedge clk); #1 we32 = 0;
    @(negedge clk); chk("x32_hartid_kept", rdata32, 64'h7);
    @(posedge clk); #1 raddr32 = 12'h7C0;
    @(negedge clk);
    chk("x32_unimpl_illegal", illegal32, 1'b1);
    chk("x32_unimpl_rdata", rdata32, 64'd0);
    @(posedge clk); #1 raddr32 = 12'h301;
    @(negedge clk); chk("x32_misa", rdata32, 64'h4000_0100);
    @(posedge clk); #1 we32 = 1; waddr32 = 12'hB02; wdata32 = '1; retire32 = 1; raddr32 = 12'hB02;
    @(posedge clk); #1 we32 = 0;
    @(negedge clk); chk("x32_instret_ones", rdata32, 64'hFFFF_FFFF);
    @(posedge clk); #1 retire32 = 0;
    @(negedge clk); chk("x32_instret_wrap", rdata32, 64'd0);
    @(posedge clk); #1 we32 = 1; waddr32 = 12'h340; wdata32 = 32'hDEAD_BEEF; raddr32 = 12'h340;
    @(posedge clk); #1 we32 = 0;
    @(negedge clk); chk("x32_mscratch", rdata32, 64'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csr_trap_file.md
CSR_TRAP_FILE -- requirements
Module: csr_trap_file

Interface
REQ-001 SHALL have parameter XLEN, default 64: data width of all CSRs and data ports; legal values 32 and 64.
REQ-002 SHALL have parameter HART_ID, default 0: constant value returned for mhartid.
REQ-003 SHALL have parameter MTVEC_RST, default 0: reset value of mtvec.
REQ-004 SHALL have parameter MISA_VAL, default RV64I encoding: constant value returned for misa.
REQ-005 SHALL have these ports:
- cpu_clk_50M  in  1  single clock, all state on rising edge.
- cpu_rst_n  in  1  reset, asynchronous, active-low.
- csr_raddr  in  12  CSR read address.
- csr_rdata  out  XLEN  CSR read data.
- csr_waddr  in  12  CSR write address.
- csr_wdata  in  XLEN  CSR write data.
- csr_we  in  1  write enable.
- csr_illegal  out  1  access to an unimplemented CSR, or a write to a read-only CSR.
- inst_retire  in  1  one instruction retired this cycle.
- ecall_req  in  1  ecall at writeback.
- mret_req  in  1  mret at writeback.
- exc_pc  in  XLEN  PC of the instruction at writeback.
- timer_irq  in  1  level machine-timer interrupt.
- ext_irq  in  1  level machine-external interrupt.
- trap_taken  out  1  redirect pulse.
- trap_target  out  XLEN  redirect PC.
- busy  out  1  high while FSM is not IDLE.

Function
REQ-006 SHALL implement the following CSRs:
- mstatus 0x300: writable bits MIE[3], MPIE[7], MPP[12:11]; all other bits read 0.
- sstatus 0x100: read-only view of mstatus bits SD and [16:13].
- misa 0x301: read-only.
- mie 0x304: writable bits MTIE[7], MEIE[11].
- mtvec 0x305: bits [1:0] forced to 00.
- mscratch 0x340: fully writable.
- mepc 0x341: bits [1:0] forced to 00.
- mcause 0x342: fully writable.
- mip 0x344: read-only; MTIP[7]=timer_irq, MEIP[11]=ext_irq.
- mcycle 0xB00, minstret 0xB02: writable counters.
- mhartid 0xF14: read-only.
REQ-007 Reads SHALL be combinational. Same-cycle write to the same address SHALL bypass: csr_rdata = masked csr_wdata.
REQ-008 Unimplemented read address SHALL give csr_rdata=0 and csr_illegal=1 (combinational).
REQ-009 csr_we to a read-only or unimplemented address SHALL set csr_illegal=1 and modify no state.
REQ-010 Interrupt pending: irq_e = ext_irq & MEIE & MIE; irq_t = timer_irq & MTIE & MIE.
REQ-011 Event priority, in IDLE only: irq_e > irq_t > ecall_req > mret_req > csr_we. Exactly one event SHALL take effect per cycle; lower-priority events are dropped.
REQ-012 Trap entry at edge N:
- mepc <= exc_pc.
- mcause <= {1,0..,11} for irq_e, {1,0..,7} for irq_t, 11 for ecall.
- MPIE <= MIE; MIE <= 0; MPP <= 11.
- FSM -> TRAP.
REQ-013 mret at edge N: MIE <= MPIE; MPIE <= 1; MPP <= 00; FSM -> RET.
REQ-014 In TRAP and RET, lasting exactly one cycle (N to N+1):
- trap_taken=1.
- trap_target = mtvec in TRAP, mepc in RET.
- busy=1.
- All events SHALL be ignored; csr_we is dropped.
- FSM returns to IDLE at edge N+1.
REQ-015 mcycle SHALL increment by 1 every cycle and wrap modulo 2^XLEN. A write to mcycle SHALL load csr_wdata with no increment that cycle.
REQ-016 minstret SHALL increment on inst_retire and wrap. A write to minstret SHALL take priority over the increment.
REQ-017 A trap entry in the same cycle as inst_retire SHALL still count the retirement.
REQ-018 A write to mstatus SHALL update sstatus: SD = csr_wdata[XLEN-1], [16:13] = csr_wdata[16:13].

Reset
REQ-019 On cpu_rst_n low, asynchronously and independent of clock:
- All CSRs 0, except mtvec=MTVEC_RST.
- FSM=IDLE.
- trap_taken=0, busy=0.
REQ-020 Reset asserted while in TRAP or RET SHALL abort the redirect: trap_taken=0 immediately.

Structure
REQ-021 The following SHALL reside in the shared defines/package:
- CSR address constants.
- mcause codes.
- mstatus bit indices.
- FSM state encoding (IDLE, TRAP, RET).
REQ-022 The counter pair (mcycle, minstret) SHALL be a sub-module csr_counters, parametrised by XLEN.

Verification
REQ-023 Bench SHALL cover these scenarios:
- Reset: release reset -> mtvec=MTVEC_RST, mcycle=0; 10 cycles later mcycle=10.
- ECALL: mtvec=0x8000_0100, exc_pc=0x8000_0040, ecall_req -> next cycle trap_taken=1, trap_target=0x8000_0100; mepc=0x8000_0040, mcause=11, MIE=0, MPIE=old MIE.
- Timer vs ecall: MIE=1, MTIE=1, timer_irq=1 together with ecall_req -> mcause=0x8000_0000_0000_0007, ecall dropped.
- mret, then write during RET: after trap, mret_req -> trap_target=mepc, MIE restored, MPP=00; a write to mscratch issued during RET is not applied.
- Counter write/wrap: write minstret=all-ones with inst_retire=1 -> minstret=all-ones; next retire -> 0.
- Illegal access: write to mhartid or read of 0x7C0 -> csr_illegal=1, state unchanged; repeat with XLEN=32.
